reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Tracks in-flight register-file writes between ID issue and WB retire, and
//  raises a stall to ID on read-after-write hazards the forwarding paths cannot
//  cover. Sits beside the register file in ID; decoder drives issue/source
//  fields, WB (or squash logic) drives retire. Register 0 is never tracked.
// PARAMETERS
//  ADDR_W    4   register address width
//  NUM_REGS  16  tracked registers (addresses 0..NUM_REGS-1)
//  CNT_W     2   per-register in-flight counter width (max 2**CNT_W-1)
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  iss_valid_i   in   1       ID has an instruction attempting to issue
//  iss_wen_i     in   1       issuing instruction writes a register
//  iss_waddr_i   in   ADDR_W  destination register
//  iss_load_i    in   1       issuing instruction is a load (LW/LW_SP)
//  rs1_en_i      in   1       source 1 read enable
//  rs1_addr_i    in   ADDR_W  source 1 address
//  rs2_en_i      in   1       source 2 read enable
//  rs2_addr_i    in   ADDR_W  source 2 address
//  ret_valid_i   in   1       one tracked write leaves the pipeline this cycle
//  ret_addr_i    in   ADDR_W  its destination register
//  ret_load_i    in   1       it was a load
//  stall_o       out  1       hold PC/IF/ID, inject bubble into EX (comb.)
//  issue_o       out  1       iss_valid_i & ~stall_o (issue accepted)
//  inflight_o    out  CNT_W+2 total tracked writes in flight (registered)
// BEHAVIOUR
//  - State: pend_cnt[r], load_cnt[r] (CNT_W each), r=1..NUM_REGS-1; total count.
//  - Reset: all counters 0; stall_o=0, issue_o=0, inflight_o=0 one cycle later
//    and held while rst=1; rst dominates issue/retire in the same cycle.
//  - Accepted issue (issue_o=1, iss_wen_i=1, iss_waddr_i!=0): pend_cnt+1;
//    load_cnt+1 if iss_load_i. Address 0 or wen=0: no state change.
//  - Retire (ret_valid_i, ret_addr_i!=0): pend_cnt-1; load_cnt-1 if ret_load_i.
//    Retire of a zero counter is a protocol error: counter holds at 0
//    (simulation $display warning), never wraps.
//  - Issue and retire same register same cycle: net 0 per counter.
//  - hazard(src) = en & addr!=0 & cnt_eff(addr)!=0, where cnt_eff subtracts a
//    same-cycle retire to that register (WB bypass in regfile covers it).
//  - Structural stall: iss_wen_i & pend_cnt[waddr]==max & no same-cycle retire
//    of waddr -> stall_o=1 (counter never overflows).
//  - stall_o = iss_valid_i & (hazard(rs1) | hazard(rs2) | structural).
//    stall_o is 0 whenever iss_valid_i=0. Zero-cycle decision, no FSM latency.
//  - inflight_o = sum of pend_cnt, updated on the clock edge after the event.
// CONFIGURATION
//  SCOREBOARD_FWD_EN defined: EX/MEM forwarding exists; hazard uses load_cnt
//    only (load-use stall, 1 bubble for adjacent LW->use).
//  Not defined: no forwarding; hazard uses pend_cnt (any pending write stalls
//    until retire). load_cnt still maintained; structural rule unchanged.
// TESTING
//  1 rst=1 3 cycles with issue/retire active -> counters, stall_o, inflight_o=0.
//  2 issue ADDU wr r3, next cycle read r3: FWD_EN -> stall_o=0; no FWD ->
//    stall_o=1 until ret r3, then 0 same cycle as retire (bypass).
//  3 issue LW r2, next read r2 with FWD_EN -> stall_o=1 until ret_load r2;
//    inflight_o 0->1->0.
//  4 issue wr r5 three times (CNT_W=2), 4th issue r5 -> stall_o=1, issue_o=0;
//    same cycle ret r5 -> stall_o=0, pend_cnt[5] stays 3.
//  5 issue wr r0 and read r0 -> no counter change, stall_o=0 in both configs.
//  6 issue LW r4 and ret r4 same cycle with cnt=1 -> cnt stays 1, no wrap;
//    spurious retire of r6 at 0 -> stays 0, warning printed.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks register writes that have issued in ID but not yet retired in WB.
//   It raises stall_o when an issuing instruction would read a register whose
//   value is not yet available. It also stalls when the per-register in-flight
//   counter for the destination register is already at its maximum.
//
//   Optional feature macro: SCOREBOARD_FWD_EN
//     defined   - EX/MEM forwarding exists, so only pending loads cause a
//                 read hazard (load-use bubble).
//     undefined - no forwarding, so any pending write causes a read hazard
//                 until it retires.
//
//   Register 0 is hardwired, so it is never tracked. Its counters stay at zero.
//   A retire that finds a counter already at zero is an upstream protocol
//   error. The counter saturates at zero and a simulation warning is printed.
module reg_scoreboard #(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid_i,
  input  logic              iss_wen_i,
  input  logic [ADDR_W-1:0] iss_waddr_i,
  input  logic              iss_load_i,
  input  logic              rs1_en_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic              rs2_en_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  input  logic              ret_valid_i,
  input  logic [ADDR_W-1:0] ret_addr_i,
  input  logic              ret_load_i,
  output logic              stall_o,
  output logic              issue_o,
  output logic [CNT_W+1:0]  inflight_o
);

  localparam int               TOT_W   = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Per-register counters. Entry 0 exists only to keep indexing uniform.
  logic [CNT_W-1:0] pend_cnt_reg  [NUM_REGS];
  logic [CNT_W-1:0] pend_cnt_next [NUM_REGS];
  logic [CNT_W-1:0] load_cnt_reg  [NUM_REGS];
  logic [CNT_W-1:0] load_cnt_next [NUM_REGS];
  logic [TOT_W-1:0] inflight_reg;
  logic [TOT_W-1:0] inflight_next;

  // One bit per register. The g_reg generate loop below fills these in.
  logic [NUM_REGS-1:0] wr_sel;          // issue destination decode
  logic [NUM_REGS-1:0] rs1_sel;         // source 1 decode (enable folded in)
  logic [NUM_REGS-1:0] rs2_sel;         // source 2 decode (enable folded in)
  logic [NUM_REGS-1:0] iss_hit;         // accepted tracked write to this reg
  logic [NUM_REGS-1:0] iss_load_hit;    // ... and it is a load
  logic [NUM_REGS-1:0] ret_hit;         // retire to this reg this cycle
  logic [NUM_REGS-1:0] ret_load_hit;    // ... and it was a load
  logic [NUM_REGS-1:0] pend_busy;       // pend count after same-cycle retire != 0
  logic [NUM_REGS-1:0] load_busy;       // load count after same-cycle retire != 0
  logic [NUM_REGS-1:0] pend_full;       // counter saturated, no retire to free it
  logic [NUM_REGS-1:0] haz_busy;        // busy flavour selected by configuration
  logic [NUM_REGS-1:0] pend_underflow;  // retire found pend count at zero
  logic [NUM_REGS-1:0] load_underflow;  // load retire found load count at zero

  logic hazard_rs1;
  logic hazard_rs2;
  logic structural;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // r0 is hardwired and never participates in any hazard.
        assign wr_sel[gi]         = 1'b0;
        assign rs1_sel[gi]        = 1'b0;
        assign rs2_sel[gi]        = 1'b0;
        assign iss_hit[gi]        = 1'b0;
        assign iss_load_hit[gi]   = 1'b0;
        assign ret_hit[gi]        = 1'b0;
        assign ret_load_hit[gi]   = 1'b0;
        assign pend_busy[gi]      = 1'b0;
        assign load_busy[gi]      = 1'b0;
        assign pend_full[gi]      = 1'b0;
        assign pend_underflow[gi] = 1'b0;
        assign load_underflow[gi] = 1'b0;
      end else begin : g_track
        assign wr_sel[gi]  = (iss_waddr_i == ADDR_W'(gi));
        assign rs1_sel[gi] = rs1_en_i & (rs1_addr_i == ADDR_W'(gi));
        assign rs2_sel[gi] = rs2_en_i & (rs2_addr_i == ADDR_W'(gi));

        // Counters only move on an accepted issue, never on a stalled attempt.
        assign iss_hit[gi]      = issue_o & iss_wen_i & wr_sel[gi];
        assign iss_load_hit[gi] = iss_hit[gi] & iss_load_i;
        assign ret_hit[gi]      = ret_valid_i & (ret_addr_i == ADDR_W'(gi));
        assign ret_load_hit[gi] = ret_hit[gi] & ret_load_i;

        // The regfile write-through bypass delivers a value that retires this
        // cycle, so a count of exactly one that is retiring is not a hazard.
        assign pend_busy[gi] = (pend_cnt_reg[gi] != '0) &&
                               !((pend_cnt_reg[gi] == CNT_ONE) && ret_hit[gi]);
        assign load_busy[gi] = (load_cnt_reg[gi] != '0) &&
                               !((load_cnt_reg[gi] == CNT_ONE) && ret_load_hit[gi]);

        // A same-cycle retire frees one slot, so issuing into it is safe.
        assign pend_full[gi] = (pend_cnt_reg[gi] == CNT_MAX) && !ret_hit[gi];

        assign pend_underflow[gi] = ret_hit[gi] && (pend_cnt_reg[gi] == '0);
        assign load_underflow[gi] = ret_load_hit[gi] && (load_cnt_reg[gi] == '0);
      end

`ifdef SCOREBOARD_FWD_EN
      // Forwarding covers ALU results, so only an outstanding load blocks a read.
      assign haz_busy[gi] = load_busy[gi];
`else
      // No forwarding, so every outstanding write blocks a read until retire.
      assign haz_busy[gi] = pend_busy[gi];
`endif
    end
  endgenerate

  // Zero-cycle stall/issue decision. Reset forces both low.
  always_comb begin
    hazard_rs1 = |(rs1_sel & haz_busy);
    hazard_rs2 = |(rs2_sel & haz_busy);
    structural = iss_wen_i & |(wr_sel & pend_full);
    stall_o    = iss_valid_i & ~rst & (hazard_rs1 | hazard_rs2 | structural);
    issue_o    = iss_valid_i & ~rst & ~stall_o;
  end

  // Next counter values. Issue and retire to the same register cancel out, and
  // an unmatched retire saturates at zero instead of wrapping.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_cnt_next[r] = pend_cnt_reg[r];
      load_cnt_next[r] = load_cnt_reg[r];
      if (iss_hit[r] && !ret_hit[r]) begin
        pend_cnt_next[r] = pend_cnt_reg[r] + CNT_ONE;
      end else if (!iss_hit[r] && ret_hit[r] && (pend_cnt_reg[r] != '0)) begin
        pend_cnt_next[r] = pend_cnt_reg[r] - CNT_ONE;
      end
      if (iss_load_hit[r] && !ret_load_hit[r]) begin
        load_cnt_next[r] = load_cnt_reg[r] + CNT_ONE;
      end else if (!iss_load_hit[r] && ret_load_hit[r] && (load_cnt_reg[r] != '0)) begin
        load_cnt_next[r] = load_cnt_reg[r] - CNT_ONE;
      end
    end
  end

  // Total in flight is the sum of the next per-register pending counts, so it
  // always agrees with the counter array one edge after any event.
  always_comb begin
    inflight_next = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inflight_next = inflight_next + TOT_W'(pend_cnt_next[r]);
    end
  end

  // Counter and total state. Reset takes priority over issue and retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_cnt_reg[r] <= '0;
        load_cnt_reg[r] <= '0;
      end
      inflight_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend_cnt_reg[r] <= pend_cnt_next[r];
        load_cnt_reg[r] <= load_cnt_next[r];
      end
      inflight_reg <= inflight_next;
    end
  end

  assign inflight_o = inflight_reg;

`ifndef SYNTHESIS
  // Report retires that have no matching tracked write.
  always_ff @(posedge clk) begin
    if (!rst && (|pend_underflow)) begin
      $warning("reg_scoreboard: retire of r%0d with nothing pending, count held at 0",
               ret_addr_i);
    end
    if (!rst && (|load_underflow)) begin
      $warning("reg_scoreboard: load retire of r%0d with no load pending, count held at 0",
               ret_addr_i);
    end
  end
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard.
//   Table-driven directed vectors cover each scenario, followed by two
//   hand-written multi-cycle sequences. Expected values are hand computed.
//   The read-hazard expectations depend on SCOREBOARD_FWD_EN.
`timescale 1ns/1ps
module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       iss_valid_i, iss_wen_i, iss_load_i;
  logic [3:0] iss_waddr_i;
  logic       rs1_en_i, rs2_en_i;
  logic [3:0] rs1_addr_i, rs2_addr_i;
  logic       ret_valid_i, ret_load_i;
  logic [3:0] ret_addr_i;
  logic       stall_o, issue_o;
  logic [3:0] inflight_o;

  reg_scoreboard #(.ADDR_W(4), .NUM_REGS(16), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .iss_valid_i (iss_valid_i),
    .iss_wen_i   (iss_wen_i),
    .iss_waddr_i (iss_waddr_i),
    .iss_load_i  (iss_load_i),
    .rs1_en_i    (rs1_en_i),
    .rs1_addr_i  (rs1_addr_i),
    .rs2_en_i    (rs2_en_i),
    .rs2_addr_i  (rs2_addr_i),
    .ret_valid_i (ret_valid_i),
    .ret_addr_i  (ret_addr_i),
    .ret_load_i  (ret_load_i),
    .stall_o     (stall_o),
    .issue_o     (issue_o),
    .inflight_o  (inflight_o)
  );

  always #5 clk = ~clk;

`ifdef SCOREBOARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic       iv, wen, ld;
    logic [3:0] wa;
    logic       r1e;
    logic [3:0] r1;
    logic       r2e;
    logic [3:0] r2;
    logic       rv;
    logic [3:0] ra;
    logic       rl;
    logic       es, ei;   // expected stall_o / issue_o in this cycle
    logic [3:0] ef;       // expected inflight_o after the clock edge
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input string name, input logic r,
                              input logic iv, input logic wen, input logic ld, input logic [3:0] wa,
                              input logic r1e, input logic [3:0] r1,
                              input logic r2e, input logic [3:0] r2,
                              input logic rv, input logic [3:0] ra, input logic rl,
                              input logic es, input logic ei, input logic [3:0] ef);
    vec_t v;
    v.name = name; v.rst = r;
    v.iv = iv; v.wen = wen; v.ld = ld; v.wa = wa;
    v.r1e = r1e; v.r1 = r1; v.r2e = r2e; v.r2 = r2;
    v.rv = rv; v.ra = ra; v.rl = rl;
    v.es = es; v.ei = ei; v.ef = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check the combinational
  // outputs mid-cycle, then check the registered total just after the edge.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    iss_valid_i = v.iv; iss_wen_i = v.wen; iss_load_i = v.ld; iss_waddr_i = v.wa;
    rs1_en_i = v.r1e; rs1_addr_i = v.r1; rs2_en_i = v.r2e; rs2_addr_i = v.r2;
    ret_valid_i = v.rv; ret_addr_i = v.ra; ret_load_i = v.rl;
    #1;
    chk({v.name, " stall"}, int'(stall_o), int'(v.es));
    chk({v.name, " issue"}, int'(issue_o), int'(v.ei));
    @(posedge clk);
    #1;
    chk({v.name, " inflight"}, int'(inflight_o), int'(v.ef));
    $display("vec %-18s stall=%0d issue=%0d inflight=%0d", v.name, stall_o, issue_o, inflight_o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iss_valid_i = 0; iss_wen_i = 0; iss_load_i = 0; iss_waddr_i = 0;
    rs1_en_i = 0; rs1_addr_i = 0; rs2_en_i = 0; rs2_addr_i = 0;
    ret_valid_i = 0; ret_addr_i = 0; ret_load_i = 0;

    // Reset held for three cycles while issue and retire are active.
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("rst_active", 1, 1,1,0,4'd1, 1,4'd1, 0,4'd0, 1,4'd2,0, 0,0,4'd0));
    vecs.push_back(mk("idle", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,0,4'd0));
    // ALU write to r3, then reads of r3.
    vecs.push_back(mk("t2_wr_r3", 0, 1,1,0,4'd3, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t2_rd_r3_a", 0, 1,0,0,4'd0, 1,4'd3, 0,4'd0, 0,4'd0,0, !FWD,FWD,4'd1));
    vecs.push_back(mk("t2_rd_r3_b", 0, 1,0,0,4'd0, 1,4'd3, 0,4'd0, 0,4'd0,0, !FWD,FWD,4'd1));
    vecs.push_back(mk("t2_rd_r3_ret", 0, 1,0,0,4'd0, 1,4'd3, 0,4'd0, 1,4'd3,0, 0,1,4'd0));
    // A source that is not enabled never causes a hazard. rs2 does.
    vecs.push_back(mk("t2_wr_r9", 0, 1,1,0,4'd9, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t2_noen_r9", 0, 1,0,0,4'd0, 0,4'd9, 0,4'd9, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t2_rs2_r9", 0, 1,0,0,4'd0, 0,4'd0, 1,4'd9, 0,4'd0,0, !FWD,FWD,4'd1));
    vecs.push_back(mk("t2_ret_r9", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd9,0, 0,0,4'd0));
    // Load to r2, then use of r2 stalls in both configurations until it retires.
    vecs.push_back(mk("t3_lw_r2", 0, 1,1,1,4'd2, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t3_use_r2", 0, 1,0,0,4'd0, 0,4'd0, 1,4'd2, 0,4'd0,0, 1,0,4'd1));
    vecs.push_back(mk("t3_use_r2_ret", 0, 1,0,0,4'd0, 0,4'd0, 1,4'd2, 1,4'd2,1, 0,1,4'd0));
    // Saturate the r5 counter to exercise the structural stall.
    vecs.push_back(mk("t4_wr_r5_1", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t4_wr_r5_2", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd2));
    vecs.push_back(mk("t4_wr_r5_3", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd3));
    vecs.push_back(mk("t4_full", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 0,4'd0,0, 1,0,4'd3));
    vecs.push_back(mk("t4_full_ret", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 1,4'd5,0, 0,1,4'd3));
    vecs.push_back(mk("t4_still_full", 0, 1,1,0,4'd5, 0,4'd0, 0,4'd0, 0,4'd0,0, 1,0,4'd3));
    vecs.push_back(mk("t4_drain_noval", 0, 0,1,0,4'd5, 1,4'd5, 1,4'd5, 1,4'd5,0, 0,0,4'd2));
    vecs.push_back(mk("t4_drain_2", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd5,0, 0,0,4'd1));
    vecs.push_back(mk("t4_drain_3", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd5,0, 0,0,4'd0));
    // r0 is never tracked.
    vecs.push_back(mk("t5_wr_r0", 0, 1,1,0,4'd0, 1,4'd0, 1,4'd0, 0,4'd0,0, 0,1,4'd0));
    vecs.push_back(mk("t5_lw_r0", 0, 1,1,1,4'd0, 1,4'd0, 1,4'd0, 0,4'd0,0, 0,1,4'd0));
    // Simultaneous issue and retire to r4, followed by a spurious retire of r6.
    vecs.push_back(mk("t6_lw_r4", 0, 1,1,1,4'd4, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t6_lw_ret_r4", 0, 1,1,1,4'd4, 0,4'd0, 0,4'd0, 1,4'd4,1, 0,1,4'd1));
    vecs.push_back(mk("t6_use_r4", 0, 1,0,0,4'd0, 1,4'd4, 0,4'd0, 0,4'd0,0, 1,0,4'd1));
    vecs.push_back(mk("t6_ret_r4", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd4,1, 0,0,4'd0));
    vecs.push_back(mk("t6_use_r4_free", 0, 1,0,0,4'd0, 1,4'd4, 0,4'd0, 0,4'd0,0, 0,1,4'd0));
    vecs.push_back(mk("t6_spur_r6", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd6,1, 0,0,4'd0));
    vecs.push_back(mk("t6_rd_r6", 0, 1,0,0,4'd0, 1,4'd6, 1,4'd6, 0,4'd0,0, 0,1,4'd0));
    vecs.push_back(mk("t6_wr_r6", 0, 1,1,0,4'd6, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    vecs.push_back(mk("t6_ret_r6", 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'd6,0, 0,0,4'd0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Hand sequence: reset in the middle of traffic wipes the counters.
    apply(mk("seqA_wr_r8_1", 0, 1,1,0,4'd8, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd1));
    apply(mk("seqA_wr_r8_2", 0, 1,1,0,4'd8, 0,4'd0, 0,4'd0, 0,4'd0,0, 0,1,4'd2));
    apply(mk("seqA_rst", 1, 1,1,0,4'd8, 1,4'd8, 0,4'd0, 1,4'd8,0, 0,0,4'd0));
    apply(mk("seqA_rd_r8", 0, 1,0,0,4'd0, 1,4'd8, 0,4'd0, 0,4'd0,0, 0,1,4'd0));

    // Hand sequence: many registers in flight at once, then drain in order.
    for (int r = 1; r <= 10; r++)
      apply(mk($sformatf("seqB_wr_r%0d", r), 0, 1,1,0,4'(r), 0,4'd0, 0,4'd0, 0,4'd0,0,
               0,1,4'(r)));
    apply(mk("seqB_rd_r7", 0, 1,0,0,4'd0, 1,4'd7, 0,4'd0, 0,4'd0,0, !FWD,FWD,4'd10));
    for (int r = 1; r <= 10; r++)
      apply(mk($sformatf("seqB_ret_r%0d", r), 0, 0,0,0,4'd0, 0,4'd0, 0,4'd0, 1,4'(r),0,
               0,0,4'(10 - r)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
